// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture/serializer slice.
// Default geometry here matches the top-level parameter defaults.
package adc_capture_pkg;

  localparam int NCHAN_DEF       = 2;
  localparam int SPW_DEF         = 8;
  localparam int LANE_BITS_DEF   = 16;
  localparam int SAMPLE_BITS_DEF = 12;
  localparam int DEPTH_DEF       = 64;

  localparam int WORD_BITS = SPW_DEF * LANE_BITS_DEF;
  localparam int ADDR_BITS = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DUMP    = 2'd2
  } state_e;

  // RFDC lanes are MSB-aligned, so the sample is the top SAMPLE_BITS of lane k.
  function automatic logic [SAMPLE_BITS_DEF-1:0] lane_sample(
    input logic [WORD_BITS-1:0] word,
    input int unsigned          k
  );
    return word[k*LANE_BITS_DEF + LANE_BITS_DEF - 1 -: SAMPLE_BITS_DEF];
  endfunction

endpackage

// File: rtl/adc_capture_serializer_if.sv
// Stream, trigger and serialized-output bundle between the RFDC/ILA side and
// the capture serializer.
interface adc_capture_serializer_if #(
  parameter int NCHAN       = 2,
  parameter int SPW         = 8,
  parameter int LANE_BITS   = 16,
  parameter int SAMPLE_BITS = 12
);
  localparam int SEL_BITS = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN*SPW*LANE_BITS-1:0] adc_in;
  logic [NCHAN-1:0]               adc_tvalid;
  logic [SEL_BITS-1:0]            chan_sel;
  logic                           trigger_in;
  logic                           trigger_ack;
  logic [SAMPLE_BITS-1:0]         adc_out;
  logic                           adc_valid;
  logic                           adc_last;
  logic                           busy;
  logic [7:0]                     overrun_count;

  modport master (
    output adc_in, adc_tvalid, chan_sel, trigger_in,
    input  trigger_ack, adc_out, adc_valid, adc_last, busy, overrun_count
  );

  modport slave (
    input  adc_in, adc_tvalid, chan_sel, trigger_in,
    output trigger_ack, adc_out, adc_valid, adc_last, busy, overrun_count
  );

endinterface

// File: rtl/adc_capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module adc_capture_ram #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_serializer.sv
// Captures DEPTH words of one RFDC channel on an ILA trigger, then replays
// them one sample per clock. Optional macro: ADC_CAPTURE_TVALID_GATE_EN.
//
// state   | meaning
// IDLE    | waiting for trigger_in, outputs quiet
// CAPTURE | writing selected channel words into the buffer
// DUMP    | replaying samples; final cycle clears valid/last
module adc_capture_serializer
  import adc_capture_pkg::*;
#(
  parameter int NCHAN       = NCHAN_DEF,
  parameter int SPW         = SPW_DEF,
  parameter int LANE_BITS   = LANE_BITS_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input logic                     aclk,
  input logic                     reset,
  adc_capture_serializer_if.slave bus
);

  localparam int WBITS    = SPW * LANE_BITS;
  localparam int AW       = $clog2(DEPTH);
  localparam int LW       = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int SEL_BITS = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [1:0] S_DUMP    = ST_DUMP;

  logic [1:0]             state;
  logic [SEL_BITS-1:0]    sel;
  logic [AW-1:0]          waddr;
  logic [AW-1:0]          word_idx;
  logic [LW-1:0]          lane;
  logic                   trig_q;
  logic                   ack_r;
  logic [SAMPLE_BITS-1:0] out_r;
  logic                   valid_r;
  logic                   last_r;
  logic [7:0]             ovr_r;

  logic [WBITS-1:0]       sel_word;
  logic [WBITS-1:0]       rd_word;
  logic [SAMPLE_BITS-1:0] sample;
  logic                   wr_en;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic                   lane_end;

  always_comb begin
    sel_word = '0;
    for (int c = 0; c < NCHAN; c++)
      if (int'(sel) == c) sel_word = bus.adc_in[c*WBITS +: WBITS];
  end

`ifdef ADC_CAPTURE_TVALID_GATE_EN
  logic sel_tvalid;

  always_comb begin
    sel_tvalid = 1'b0;
    for (int c = 0; c < NCHAN; c++)
      if (int'(sel) == c) sel_tvalid = bus.adc_tvalid[c];
  end

  assign wr_en = (state == S_CAPTURE) && sel_tvalid;
`else
  logic unused_tvalid;
  assign unused_tvalid = ^bus.adc_tvalid;
  assign wr_en = (state == S_CAPTURE);
`endif

  assign lane_end = (int'(lane) == SPW - 1);

  // Word 0 is prefetched during CAPTURE; each later word is fetched on the
  // last lane of the previous one so rd_word is steady for a whole word.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = word_idx + 1'b1;
    if (state == S_CAPTURE) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if (state == S_DUMP && !last_r && lane_end) begin
      rd_en = 1'b1;
    end
  end

  always_comb begin
    sample = rd_word[int'(lane)*LANE_BITS + LANE_BITS - 1 -: SAMPLE_BITS];
  end

  adc_capture_ram #(
    .WIDTH (WBITS),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (wr_en),
    .waddr (waddr),
    .wdata (sel_word),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      sel      <= '0;
      waddr    <= '0;
      word_idx <= '0;
      lane     <= '0;
      trig_q   <= 1'b0;
      ack_r    <= 1'b0;
      out_r    <= '0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      ovr_r    <= '0;
    end else begin
      trig_q <= bus.trigger_in;
      ack_r  <= 1'b0;

      if (state != S_IDLE && bus.trigger_in && !trig_q && ovr_r != 8'hFF)
        ovr_r <= ovr_r + 8'd1;

      case (state)
        S_IDLE: begin
          waddr    <= '0;
          word_idx <= '0;
          lane     <= '0;
          valid_r  <= 1'b0;
          last_r   <= 1'b0;
          if (bus.trigger_in) begin
            sel   <= (int'(bus.chan_sel) < NCHAN) ? bus.chan_sel : '0;
            ack_r <= 1'b1;
            state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (wr_en) begin
            waddr <= waddr + 1'b1;
            if (int'(waddr) == DEPTH - 1) state <= S_DUMP;
          end
        end

        S_DUMP: begin
          if (last_r) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            valid_r <= 1'b1;
            out_r   <= sample;
            last_r  <= (int'(word_idx) == DEPTH - 1) && lane_end;
            if (lane_end) begin
              lane     <= '0;
              word_idx <= word_idx + 1'b1;
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.trigger_ack   = ack_r;
  assign bus.adc_out       = out_r;
  assign bus.adc_valid     = valid_r;
  assign bus.adc_last      = last_r;
  assign bus.busy          = (state != S_IDLE);
  assign bus.overrun_count = ovr_r;

endmodule

// File: tb/tb_adc_capture_serializer.sv
// Randomized directed bench for adc_capture_serializer: a queue-based model of
// the captured words predicts every serialized sample, handshake and counter.
module tb_adc_capture_serializer;

  localparam int NCHAN       = 3;
  localparam int SPW         = 8;
  localparam int LANE_BITS   = 16;
  localparam int SAMPLE_BITS = 12;
  localparam int DEPTH       = 16;
  localparam int WB          = SPW * LANE_BITS;
  localparam int NS          = DEPTH * SPW;
  localparam int SEL_BITS    = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic aclk  = 1'b0;
  logic reset = 1'b1;

  always #5 aclk = ~aclk;

  adc_capture_serializer_if #(
    .NCHAN(NCHAN), .SPW(SPW), .LANE_BITS(LANE_BITS), .SAMPLE_BITS(SAMPLE_BITS)
  ) bus ();

  adc_capture_serializer #(
    .NCHAN(NCHAN), .SPW(SPW), .LANE_BITS(LANE_BITS),
    .SAMPLE_BITS(SAMPLE_BITS), .DEPTH(DEPTH)
  ) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  int passed  = 0;
  int total   = 0;
  int exp_ovr = 0;
  logic [WB-1:0] words[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_sample(input logic [WB-1:0] w, input int k);
    logic [WB-1:0] sh;
    sh = w >> (k*LANE_BITS + (LANE_BITS - SAMPLE_BITS));
    return 32'(sh[SAMPLE_BITS-1:0]);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NCHAN*WB/32; i++) bus.adc_in[i*32 +: 32] = $urandom;
    bus.adc_tvalid = NCHAN'($urandom);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge aclk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_valid", 32'(bus.adc_valid), 32'd0);
      drive_data();
      bus.trigger_in = 1'b0;
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the
  // first IDLE cycle after the dump (or after an injected reset).
  task automatic capture(input int sel_in, input bit hold, input bit pulses, input int reset_at);
    int  eff, n, L, s;
    bit  gate, exp_valid, exp_busy, pulse_now;
`ifdef ADC_CAPTURE_TVALID_GATE_EN
    gate = 1'b1;
`else
    gate = 1'b0;
`endif
    words.delete();
    L   = -1;
    s   = 0;
    eff = (sel_in < NCHAN) ? sel_in : 0;
    bus.trigger_in = 1'b1;
    bus.chan_sel   = SEL_BITS'(sel_in);
    drive_data();
    for (n = 1; n <= 1000; n++) begin
      @(negedge aclk);
      exp_valid = (L >= 0) && (n >= L + 2) && (n < L + 2 + NS);
      exp_busy  = (L < 0) || (n < L + 2 + NS);
      s = exp_valid ? n - (L + 2) : 0;
      chk("trigger_ack", 32'(bus.trigger_ack), 32'(n == 1));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("adc_valid", 32'(bus.adc_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("adc_out", 32'(bus.adc_out), exp_sample(words[s/SPW], s % SPW));
        chk("adc_last", 32'(bus.adc_last), 32'(s == NS - 1));
      end else begin
        chk("adc_last_idle", 32'(bus.adc_last), 32'd0);
      end
      if (L >= 0 && n == L + 2 + NS) begin
        chk("overrun_count", 32'(bus.overrun_count), 32'(exp_ovr));
        break;
      end
      if (exp_valid && s == reset_at) begin
        reset = 1'b1;
        bus.trigger_in = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.adc_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_last", 32'(bus.adc_last), 32'd0);
        chk("rst_ack", 32'(bus.trigger_ack), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_count), 32'd0);
        exp_ovr = 0;
        @(negedge aclk);
        reset = 1'b0;
        break;
      end
      drive_data();
      pulse_now = pulses && exp_valid && (s == 10 || s == 20 || s == 30);
      bus.trigger_in = hold || pulse_now;
      if (pulse_now && exp_ovr < 255) exp_ovr++;
      if (L < 0 && (!gate || bus.adc_tvalid[eff])) begin
        words.push_back(bus.adc_in[eff*WB +: WB]);
        if (words.size() == DEPTH) L = n;
      end
    end
    if (n > 1000) begin
      total++;
      $error("FAIL capture_timeout observed=%0d cycles expected<=1000", n);
    end
  endtask

  initial begin
    bus.trigger_in = 1'b0;
    bus.chan_sel   = '0;
    drive_data();
    repeat (3) @(negedge aclk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_valid", 32'(bus.adc_valid), 32'd0);
    chk("reset_out", 32'(bus.adc_out), 32'd0);
    chk("reset_ack", 32'(bus.trigger_ack), 32'd0);
    chk("reset_overrun", 32'(bus.overrun_count), 32'd0);
    reset = 1'b0;
    idle(2);

    capture(1, 1'b0, 1'b0, -1);   // basic capture of channel 1
    idle(3);
    capture(3, 1'b0, 1'b0, -1);   // out-of-range select falls back to ch0
    idle(2);
    capture(0, 1'b0, 1'b1, -1);   // three pulses during dump -> overrun 3
    idle(2);
    capture(2, 1'b1, 1'b0, -1);   // trigger held through the whole run
    capture(1, 1'b0, 1'b0, -1);   // accepted on the first IDLE cycle
    idle(2);
    capture(1, 1'b0, 1'b1, 40);   // reset mid-dump clears everything
    idle(2);
    capture(2, 1'b0, 1'b0, -1);   // full dump after reset
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
